// File: rtl/serial_neuron_loader_if.sv
// Bundle between the upstream vector source, the loader and the serial core lanes.
// Handshake: a vector moves on a rising edge where in_valid & in_ready are both high; the source
// holds in_data/w_data stable with in_valid high until that edge, and in_ready never depends on in_valid.
interface serial_neuron_loader_if #(
    parameter int N     = 2,
    parameter int width = 8
);
    logic [N*width-1:0] in_data;
    logic [N*width-1:0] w_data;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       inp;
    logic [N-1:0]       w;
    logic               start;
    logic               busy;

    modport master (
        output in_data, w_data, in_valid,
        input  in_ready, inp, w, start, busy
    );

    modport slave (
        input  in_data, w_data, in_valid,
        output in_ready, inp, w, start, busy
    );
endinterface

// File: rtl/serial_neuron_loader.sv
// Double-buffered parallel-to-serial feeder: one holding register queues the next vector while the
// shift register streams the current one LSB first, sign-extended to FRAME cycles.
module serial_neuron_loader #(
    parameter int N     = 2,
    parameter int width = 8,
    parameter int FRAME = 3 * width
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_neuron_loader_if.slave bus,
    output logic                  dbg_state_o
);
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               hold_full_q, hold_full_d;
    logic [N*width-1:0] hold_in_q, hold_in_d;
    logic [N*width-1:0] hold_w_q, hold_w_d;
    logic [N*width-1:0] sh_in_q, sh_in_d;
    logic [N*width-1:0] sh_w_q, sh_w_d;
    logic [N-1:0]       inp_q, inp_d;
    logic [N-1:0]       w_q, w_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;
    logic               load;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        hold_full_d = hold_full_q;
        hold_in_d   = hold_in_q;
        hold_w_d    = hold_w_q;
        sh_in_d     = sh_in_q;
        sh_w_d      = sh_w_q;
        start_d     = 1'b0;
        load        = 1'b0;
        accept      = bus.in_valid & in_ready_q;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (k_q == LAST) begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        k_d     = '0;
                        sh_in_d = '0;
                        sh_w_d  = '0;
                    end
                end else begin
                    k_d = k_q + CNT_W'(1);
                    // Arithmetic right shift per lane: once the sign reaches bit 0 it stays there.
                    for (int i = 0; i < N; i++) begin
                        sh_in_d[i*width +: width] = {sh_in_q[i*width + width - 1],
                                                     sh_in_q[i*width + 1 +: width - 1]};
                        sh_w_d[i*width +: width]  = {sh_w_q[i*width + width - 1],
                                                     sh_w_q[i*width + 1 +: width - 1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d     = SHIFT;
            k_d         = '0;
            sh_in_d     = hold_in_q;
            sh_w_d      = hold_w_q;
            hold_full_d = 1'b0;
            start_d     = 1'b1;
        end

        // Only possible while the holding register is empty, so never on a load edge.
        if (accept) begin
            hold_in_d   = bus.in_data;
            hold_w_d    = bus.w_data;
            hold_full_d = 1'b1;
        end

        for (int i = 0; i < N; i++) begin
            inp_d[i] = sh_in_d[i*width];
            w_d[i]   = sh_w_d[i*width];
        end
        busy_d     = (state_d == SHIFT);
        in_ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            hold_full_q <= 1'b0;
            hold_in_q   <= '0;
            hold_w_q    <= '0;
            sh_in_q     <= '0;
            sh_w_q      <= '0;
            inp_q       <= '0;
            w_q         <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            hold_full_q <= hold_full_d;
            hold_in_q   <= hold_in_d;
            hold_w_q    <= hold_w_d;
            sh_in_q     <= sh_in_d;
            sh_w_q      <= sh_w_d;
            inp_q       <= inp_d;
            w_q         <= w_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.inp      = inp_q;
    assign bus.w        = w_q;
    assign bus.start    = start_q;
    assign bus.busy     = busy_q;
    assign bus.in_ready = in_ready_q;
    assign dbg_state_o  = (state_q == SHIFT);
endmodule

// File: tb/tb_serial_neuron_loader.sv
// Directed bench for serial_neuron_loader: default 24-cycle frame instance plus a FRAME=9 instance.
module tb_serial_neuron_loader;
    logic clk;
    logic rst;
    logic dbg_a;
    logic dbg_b;
    int   n_checks;
    int   n_pass;

    serial_neuron_loader_if #(.N(2), .width(8)) ifa ();
    serial_neuron_loader_if #(.N(2), .width(8)) ifb ();

    serial_neuron_loader #(.N(2), .width(8)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifa),
        .dbg_state_o (dbg_a)
    );

    serial_neuron_loader #(.N(2), .width(8), .FRAME(9)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifb),
        .dbg_state_o (dbg_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one vector on ifa and holds it until accepted (bounded).
    task automatic send(input logic [15:0] d, input logic [15:0] wv);
        logic acc;
        acc = 1'b0;
        ifa.in_data  = d;
        ifa.w_data   = wv;
        ifa.in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = ifa.in_ready;
            tick();
        end
        ifa.in_valid = 1'b0;
        check("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    // Records 24 cycles of ifa outputs starting at the current (k=0) cycle and checks them.
    task automatic frame_check(input string tag, input logic [23:0] e_i0, input logic [23:0] e_i1,
                               input logic [23:0] e_w0, input logic [23:0] e_w1,
                               input logic [23:0] e_rdy);
        logic [23:0] s_i0, s_i1, s_w0, s_w1, s_st, s_bz, s_rdy;
        for (int k = 0; k < 24; k++) begin
            s_i0[k]  = ifa.inp[0];
            s_i1[k]  = ifa.inp[1];
            s_w0[k]  = ifa.w[0];
            s_w1[k]  = ifa.w[1];
            s_st[k]  = ifa.start;
            s_bz[k]  = ifa.busy;
            s_rdy[k] = ifa.in_ready;
            tick();
        end
        check({tag, "_inp0"}, {8'd0, s_i0}, {8'd0, e_i0});
        check({tag, "_inp1"}, {8'd0, s_i1}, {8'd0, e_i1});
        check({tag, "_w0"}, {8'd0, s_w0}, {8'd0, e_w0});
        check({tag, "_w1"}, {8'd0, s_w1}, {8'd0, e_w1});
        check({tag, "_start"}, {8'd0, s_st}, 32'h000001);
        check({tag, "_busy"}, {8'd0, s_bz}, 32'hFFFFFF);
        check({tag, "_in_ready"}, {8'd0, s_rdy}, {8'd0, e_rdy});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, ifa.busy}, 32'd0);
        check({tag, "_start"}, {31'd0, ifa.start}, 32'd0);
        check({tag, "_inp"}, {30'd0, ifa.inp}, 32'd0);
        check({tag, "_w"}, {30'd0, ifa.w}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, ifa.in_ready}, 32'd1);
    endtask

    initial begin
        logic        found;
        int          lat;
        int          n_start;
        int          n_busy;
        logic [8:0]  b_i0, b_i1, b_w0, b_w1, b_st, b_bz;
        logic        acc;

        n_checks     = 0;
        n_pass       = 0;
        ifa.in_data  = '0;
        ifa.w_data   = '0;
        ifa.in_valid = 1'b0;
        ifb.in_data  = '0;
        ifb.w_data   = '0;
        ifb.in_valid = 1'b0;
        rst          = 1'b1;
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_dbg_state", {31'd0, dbg_a}, 32'd0);
        rst = 1'b1;
        tick();

        // Test 1: single vector from IDLE, latency and exact serial pattern.
        ifa.in_data  = {8'hFD, 8'h05};
        ifa.w_data   = {8'h80, 8'h40};
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        check("t1_no_early_start", {31'd0, ifa.start}, 32'd0);
        check("t1_ready_low_after_accept", {31'd0, ifa.in_ready}, 32'd0);
        tick();
        check("t1_start", {31'd0, ifa.start}, 32'd1);
        check("t1_dbg_shift", {31'd0, dbg_a}, 32'd1);
        frame_check("t1", 24'h000005, 24'hFFFFFD, 24'h000040, 24'hFFFF80, 24'hFFFFFF);
        check_idle("t6_after_frame");
        n_start = 0;
        n_busy  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_start += int'(ifa.start);
            n_busy  += int'(ifa.busy);
        end
        check("t6_no_more_start", n_start, 0);
        check("t6_stays_idle", n_busy, 0);

        // Tests 2/3: three queued vectors, back-to-back frames, third held while hold is full.
        fork
            begin
                send({8'h7F, 8'h81}, {8'h01, 8'hFE});
                send({8'h00, 8'hFF}, {8'h55, 8'hAA});
                send({8'h3C, 8'hC3}, {8'h96, 8'h69});
            end
        join_none
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            lat++;
            if (ifa.start) found = 1'b1;
        end
        check("t2_start_seen", {31'd0, found}, 32'd1);
        check("t2_latency", lat, 2);
        frame_check("t2_a", 24'hFFFF81, 24'h00007F, 24'hFFFFFE, 24'h000001, 24'h000001);
        check("t2_b2b_start", {31'd0, ifa.start}, 32'd1);
        frame_check("t3_b", 24'hFFFFFF, 24'h000000, 24'hFFFFAA, 24'h000055, 24'h000001);
        check("t3_c_start", {31'd0, ifa.start}, 32'd1);
        frame_check("t3_c", 24'hFFFFC3, 24'h00003C, 24'h000069, 24'hFFFF96, 24'hFFFFFF);
        check_idle("t3_after");

        // Test 4: asynchronous reset at k=5 with a vector queued.
        ifa.in_data  = 16'hFFFF;
        ifa.w_data   = 16'hFFFF;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_data  = 16'h1234;
        ifa.w_data   = 16'h5678;
        tick();
        check("t4_start", {31'd0, ifa.start}, 32'd1);
        tick();
        ifa.in_valid = 1'b0;
        repeat (4) tick();
        check("t4_pre_busy", {31'd0, ifa.busy}, 32'd1);
        check("t4_pre_ready", {31'd0, ifa.in_ready}, 32'd0);
        check("t4_pre_inp", {30'd0, ifa.inp}, 32'd3);
        check("t4_pre_w", {30'd0, ifa.w}, 32'd3);
        rst = 1'b0;
        #1;
        check_idle("t4_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_start = 0;
        n_busy  = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_start += int'(ifa.start);
            n_busy  += int'(ifa.busy);
        end
        check("t4_no_start", n_start, 0);
        check("t4_no_busy", n_busy, 0);

        // Test 5: FRAME=9 instance, one sign-extension cycle, back-to-back 9 apart.
        ifb.in_data  = {8'h01, 8'h80};
        ifb.w_data   = {8'h7F, 8'h80};
        ifb.in_valid = 1'b1;
        tick();
        check("t5_ready_low", {31'd0, ifb.in_ready}, 32'd0);
        tick();
        check("t5_start", {31'd0, ifb.start}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            b_i0[k] = ifb.inp[0];
            b_i1[k] = ifb.inp[1];
            b_w0[k] = ifb.w[0];
            b_w1[k] = ifb.w[1];
            b_st[k] = ifb.start;
            b_bz[k] = ifb.busy;
            acc = ifb.in_valid & ifb.in_ready;
            tick();
            if (acc) ifb.in_valid = 1'b0;
        end
        check("t5_inp0", {23'd0, b_i0}, 32'h180);
        check("t5_inp1", {23'd0, b_i1}, 32'h001);
        check("t5_w0", {23'd0, b_w0}, 32'h180);
        check("t5_w1", {23'd0, b_w1}, 32'h07F);
        check("t5_start_seq", {23'd0, b_st}, 32'h001);
        check("t5_busy_seq", {23'd0, b_bz}, 32'h1FF);
        check("t5_restart_9", {31'd0, ifb.start}, 32'd1);
        check("t5_dbg_shift", {31'd0, dbg_b}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
